// File: rtl/ysyx_24110015_mem_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the arbiter and the single-port SRAM.
// The slave modport is the arbiter's view; the master modport is the requester/SRAM side.
interface ysyx_24110015_mem_arbiter_if;
  logic        ifu_arvalid;
  logic [31:0] ifu_araddr;
  logic        ifu_arready;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        ifu_rready;

  logic        lsu_valid;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_ready;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_rready;

  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        bus_err;

  modport slave (
    input  ifu_arvalid, ifu_araddr, ifu_rready,
    input  lsu_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_rready,
    input  mem_rvalid, mem_rdata,
    output ifu_arready, ifu_rvalid, ifu_rdata,
    output lsu_ready, lsu_rvalid, lsu_rdata,
    output mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output bus_err
  );

  modport master (
    output ifu_arvalid, ifu_araddr, ifu_rready,
    output lsu_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_rready,
    output mem_rvalid, mem_rdata,
    input  ifu_arready, ifu_rvalid, ifu_rdata,
    input  lsu_ready, lsu_rvalid, lsu_rdata,
    input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  bus_err
  );
endinterface

// File: rtl/ysyx_24110015_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto one SRAM port: one transaction in flight,
// alternating priority on ties, and a wait-cycle timeout that returns 0xDEADBEEF.
module ysyx_24110015_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_24110015_mem_arbiter_if.slave   bus
);
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  state_t        state, state_nxt;
  req_t          req;
  logic          own_lsu;
  logic          last_lsu;
  logic [31:0]   resp;
  logic [CW-1:0] cnt;
  logic          err;
  logic          grant_ifu, grant_lsu, expire;

  // On a tie the requester that did not win last time gets the port.
  assign grant_ifu = bus.ifu_arvalid & (~bus.lsu_valid   | last_lsu);
  assign grant_lsu = bus.lsu_valid   & (~bus.ifu_arvalid | ~last_lsu);
  assign expire    = (cnt == CW'(TIMEOUT - 1));
  assign bus.bus_err = err;

  always_comb begin
    state_nxt       = state;
    bus.ifu_arready = 1'b0;
    bus.lsu_ready   = 1'b0;
    bus.ifu_rvalid  = 1'b0;
    bus.lsu_rvalid  = 1'b0;
    bus.ifu_rdata   = '0;
    bus.lsu_rdata   = '0;
    bus.mem_ren     = 1'b0;
    bus.mem_wen     = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_wmask   = '0;
    case (state)
      IDLE: begin
        bus.ifu_arready = grant_ifu;
        bus.lsu_ready   = grant_lsu;
        if (grant_ifu | grant_lsu) state_nxt = MEM;
      end
      MEM: begin
        // cnt is zero only in the first MEM cycle, so the strobe is a single pulse.
        bus.mem_ren   = (cnt == '0) & ~req.wen;
        bus.mem_wen   = (cnt == '0) &  req.wen;
        bus.mem_addr  = req.addr;
        bus.mem_wdata = req.wdata;
        bus.mem_wmask = req.wmask;
        if (bus.mem_rvalid | expire) state_nxt = RESP;
      end
      RESP: begin
        if (own_lsu) begin
          bus.lsu_rvalid = 1'b1;
          bus.lsu_rdata  = resp;
          if (bus.lsu_rready) state_nxt = IDLE;
        end else begin
          bus.ifu_rvalid = 1'b1;
          bus.ifu_rdata  = resp;
          if (bus.ifu_rready) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      req      <= '0;
      own_lsu  <= 1'b0;
      last_lsu <= 1'b1;
      resp     <= '0;
      cnt      <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_ifu) begin
            req      <= {1'b0, bus.ifu_araddr, 32'd0, 8'd0};
            own_lsu  <= 1'b0;
            last_lsu <= 1'b0;
            cnt      <= '0;
          end else if (grant_lsu) begin
            req      <= {bus.lsu_wen, bus.lsu_addr, bus.lsu_wdata, bus.lsu_wmask};
            own_lsu  <= 1'b1;
            last_lsu <= 1'b1;
            cnt      <= '0;
          end
        end
        MEM: begin
          cnt <= cnt + CW'(1);
          if (bus.mem_rvalid) begin
            resp <= req.wen ? 32'd0 : bus.mem_rdata;
          end else if (expire) begin
            resp <= 32'hDEADBEEF;
            err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Directed + randomized bench: a transaction-level model predicts grants, SRAM strobes,
// response data and the sticky error flag; a scripted SRAM answers with chosen latency.
module tb_ysyx_24110015_mem_arbiter;
  localparam int TO = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // model state
  bit last_ifu = 1'b0;
  bit err_m    = 1'b0;

  ysyx_24110015_mem_arbiter_if bus ();
  ysyx_24110015_mem_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.ifu_arvalid = 1'b0; bus.ifu_araddr = '0; bus.ifu_rready = 1'b0;
    bus.lsu_valid = 1'b0; bus.lsu_wen = 1'b0; bus.lsu_addr = '0;
    bus.lsu_wdata = '0; bus.lsu_wmask = '0; bus.lsu_rready = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_ren"}, bus.mem_ren, 1'b0);
    chk1({tag, "_wen"}, bus.mem_wen, 1'b0);
    chk1({tag, "_ifu_rvalid"}, bus.ifu_rvalid, 1'b0);
    chk1({tag, "_lsu_rvalid"}, bus.lsu_rvalid, 1'b0);
    chk32({tag, "_addr"}, bus.mem_addr, 32'd0);
  endtask

  // One full transaction from IDLE. lat = cycle index in MEM at which the SRAM answers
  // (lat >= TO means it never answers). The losing requester keeps its valid high.
  task automatic run_txn(input bit iv, input bit lv, input logic [31:0] ia,
                         input logic lw, input logic [31:0] la, input logic [31:0] ld,
                         input logic [7:0] lm, input int lat, input logic [31:0] rd,
                         input int hold);
    bit gi, ew, tmo;
    logic [31:0] ea, ed, er;
    logic [7:0] em;
    gi = iv && (!lv || !last_ifu);
    bus.ifu_arvalid = iv; bus.ifu_araddr = ia;
    bus.lsu_valid = lv; bus.lsu_wen = lw; bus.lsu_addr = la; bus.lsu_wdata = ld; bus.lsu_wmask = lm;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk1("grant_ifu_ready", bus.ifu_arready, gi);
    chk1("grant_lsu_ready", bus.lsu_ready, !gi);
    cyc();
    last_ifu = gi;
    if (gi) bus.ifu_arvalid = 1'b0; else bus.lsu_valid = 1'b0;
    ew = gi ? 1'b0 : lw;
    ea = gi ? ia : la;
    ed = gi ? 32'd0 : ld;
    em = gi ? 8'd0 : lm;
    tmo = (lat >= TO);
    for (int k = 0; k < TO; k++) begin
      bus.mem_rvalid = (k == lat);
      bus.mem_rdata  = (k == lat) ? rd : $urandom;
      @(negedge clk);
      chk1("mem_ren", bus.mem_ren, (k == 0) && !ew);
      chk1("mem_wen", bus.mem_wen, (k == 0) && ew);
      chk32("mem_addr", bus.mem_addr, ea);
      chk32("mem_wdata", bus.mem_wdata, ed);
      chk32("mem_wmask", {24'd0, bus.mem_wmask}, {24'd0, em});
      chk1("mem_ifu_ready", bus.ifu_arready, 1'b0);
      chk1("mem_lsu_ready", bus.lsu_ready, 1'b0);
      chk1("mem_ifu_rvalid", bus.ifu_rvalid, 1'b0);
      chk1("mem_lsu_rvalid", bus.lsu_rvalid, 1'b0);
      cyc();
      if (k == lat) break;
    end
    er = tmo ? 32'hDEADBEEF : (ew ? 32'd0 : rd);
    if (tmo) err_m = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      // non-owner rready and stray SRAM completions must both be ignored
      bus.ifu_rready = gi ? (h == hold) : 1'($urandom_range(0, 1));
      bus.lsu_rready = gi ? 1'($urandom_range(0, 1)) : (h == hold);
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      bus.mem_rdata  = $urandom;
      @(negedge clk);
      chk1("resp_ifu_rvalid", bus.ifu_rvalid, gi);
      chk1("resp_lsu_rvalid", bus.lsu_rvalid, !gi);
      chk32("resp_ifu_rdata", bus.ifu_rdata, gi ? er : 32'd0);
      chk32("resp_lsu_rdata", bus.lsu_rdata, gi ? 32'd0 : er);
      chk1("resp_ifu_ready", bus.ifu_arready, 1'b0);
      chk1("resp_lsu_ready", bus.lsu_ready, 1'b0);
      chk1("resp_ren", bus.mem_ren, 1'b0);
      chk1("resp_wen", bus.mem_wen, 1'b0);
      chk32("resp_addr", bus.mem_addr, 32'd0);
      chk1("bus_err", bus.bus_err, err_m);
      cyc();
    end
    // loser drops valid without a handshake: no SRAM access may follow
    drive_idle();
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    chk_quiet("idle");
    chk1("idle_ifu_ready", bus.ifu_arready, 1'b0);
    chk1("idle_lsu_ready", bus.lsu_ready, 1'b0);
    cyc();
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    last_ifu = 1'b0;
    err_m = 1'b0;
  endtask

  initial begin
    drive_idle();
    cyc();
    do_reset();
    @(negedge clk);
    chk_quiet("reset");
    chk1("reset_ifu_ready", bus.ifu_arready, 1'b0);
    chk1("reset_lsu_ready", bus.lsu_ready, 1'b0);
    chk1("reset_bus_err", bus.bus_err, 1'b0);
    chk32("reset_ifu_rdata", bus.ifu_rdata, 32'd0);
    chk32("reset_lsu_rdata", bus.lsu_rdata, 32'd0);
    cyc();

    // tie from reset: IFU fetch first, then LSU write
    run_txn(1, 1, 32'h8000_0000, 1'b1, 32'h8000_1000, 32'h1234_5678, 8'h0F, 1, 32'h0000_0413, 2);
    run_txn(1, 1, 32'h8000_0004, 1'b1, 32'h8000_1000, 32'h1234_5678, 8'h0F, 0, 32'hCAFE_F00D, 0);
    // backpressure: owner holds rready low for 5 cycles
    run_txn(1, 1, 32'h8000_0008, 1'b0, 32'h8000_2000, 32'h0, 8'h00, 0, 32'hA5A5_5A5A, 5);
    // single requesters, including LSU read and zero-latency SRAM
    run_txn(0, 1, 32'h0, 1'b0, 32'h8000_3000, 32'h5555_AAAA, 8'hF0, 0, 32'h0BAD_F00D, 1);
    run_txn(1, 0, 32'h8000_000C, 1'b0, 32'h0, 32'h0, 8'h00, 3, 32'h1111_2222, 0);

    for (int n = 0; n < 40; n++) begin
      int  sel, lat;
      bit  iv, lv;
      sel = $urandom_range(0, 2);
      iv = (sel != 1);
      lv = (sel != 0);
      lat = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 5);
      run_txn(iv, lv, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
              8'($urandom), lat, $urandom, $urandom_range(0, 3));
    end

    // explicit timeout, then error stays sticky through a normal transaction
    do_reset();
    run_txn(1, 0, 32'h8000_0010, 1'b0, 32'h0, 32'h0, 8'h00, TO + 5, 32'h0, 1);
    run_txn(0, 1, 32'h0, 1'b0, 32'h8000_4000, 32'h0, 8'hFF, 2, 32'h7777_8888, 0);
    chk1("sticky_err", bus.bus_err, 1'b1);
    do_reset();
    @(negedge clk);
    chk1("err_cleared", bus.bus_err, 1'b0);
    cyc();

    // reset taken mid-MEM, late SRAM completion must be dropped
    bus.ifu_arvalid = 1'b1; bus.ifu_araddr = 32'h8000_0020;
    @(negedge clk);
    chk1("rst_mid_accept", bus.ifu_arready, 1'b1);
    cyc();
    bus.ifu_arvalid = 1'b0;
    @(negedge clk);
    chk1("rst_mid_strobe", bus.mem_ren, 1'b1);
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    last_ifu = 1'b0;
    err_m = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBADB_AD00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_quiet("post_rst");
      chk1("post_rst_err", bus.bus_err, 1'b0);
      cyc();
      bus.mem_rvalid = 1'b0;
    end
    run_txn(1, 0, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 8'h00, 1, 32'h0000_0413, 0);
    run_txn(1, 1, 32'h8000_0004, 1'b0, 32'h8000_5000, 32'h0, 8'h00, 0, 32'h0000_0513, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_24110015_mem_arbiter.md
YSYX_24110015_MEM_ARBITER -- requirements
Module: ysyx_24110015_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of wait cycles in MEM before the block aborts the access.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 ifu_arvalid  input  1  IFU read request valid.
REQ-005 ifu_araddr  input  32  IFU fetch address.
REQ-006 ifu_arready  output  1  IFU request accepted this cycle.
REQ-007 ifu_rvalid  output  1  IFU response valid.
REQ-008 ifu_rdata  output  32  IFU fetched instruction.
REQ-009 ifu_rready  input  1  IFU accepts the response.
REQ-010 lsu_valid  input  1  LSU request valid.
REQ-011 lsu_wen  input  1  1 = write, 0 = read.
REQ-012 lsu_addr / lsu_wdata  input  32 each  LSU address and write data.
REQ-013 lsu_wmask  input  8  LSU byte write mask.
REQ-014 lsu_ready  output  1  LSU request accepted this cycle.
REQ-015 lsu_rvalid  output  1  LSU response valid (reads and writes).
REQ-016 lsu_rdata  output  32  LSU read data.
REQ-017 lsu_rready  input  1  LSU accepts the response.
REQ-018 mem_ren / mem_wen  output  1 each  single-cycle SRAM read/write strobes.
REQ-019 mem_addr / mem_wdata  output  32 each  SRAM address and write data.
REQ-020 mem_wmask  output  8  SRAM byte write mask.
REQ-021 mem_rvalid  input  1  SRAM completion, for both reads and writes.
REQ-022 mem_rdata  input  32  SRAM read data.
REQ-023 bus_err  output  1  sticky flag, set on any timeout.

Function
REQ-024 The block SHALL implement an FSM with the states IDLE, MEM and RESP; reset state is IDLE.
REQ-025 In IDLE, ifu_arready / lsu_ready SHALL be asserted combinationally only to the granted requester; both SHALL be 0 in MEM and RESP.
REQ-026 Grant rule in IDLE:
  - single valid requester: that requester is granted;
  - both valid: the requester that was not last_owner is granted;
  - last_owner resets to LSU, so IFU wins the first tie.
REQ-027 On the handshake (valid & ready), the block SHALL:
  - latch addr, wdata, wmask, wen and owner;
  - update last_owner to the accepted requester;
  - go to MEM.
  IFU accesses are always reads with wmask = 0.
REQ-028 Strobe timing in MEM:
  - mem_ren (read) or mem_wen (write) SHALL be asserted for exactly the first cycle in MEM;
  - mem_addr, mem_wdata and mem_wmask SHALL be held stable for the whole of MEM and SHALL be 0 outside MEM.
REQ-029 In MEM, the first mem_rvalid SHALL:
  - capture mem_rdata into the response register (a write captures 0);
  - go to RESP.
  mem_rvalid in the strobe cycle itself counts.
REQ-030 mem_rvalid SHALL be ignored in IDLE and RESP.
REQ-031 An 8-bit+ wait counter SHALL clear on entry to MEM and increment each MEM cycle; when it reaches TIMEOUT without mem_rvalid, the block SHALL:
  - go to RESP with response data 32'hDEADBEEF;
  - set bus_err.
REQ-032 In RESP:
  - only the owner's rvalid SHALL be 1, with rdata held stable;
  - the other requester's rvalid SHALL be 0 and its rdata 0;
  - the state returns to IDLE in the cycle after owner rready = 1.
REQ-033 Minimum latency for accept at edge T with a same-cycle SRAM: strobe in cycle T+1, rvalid in cycle T+2.
REQ-034 A new request SHALL NOT be accepted in the cycle the response completes; acceptance resumes in IDLE.
REQ-035 A requester dropping valid before its handshake SHALL cause no SRAM access.
REQ-036 Only one transaction SHALL be outstanding at any time.

Reset
REQ-037 When rst = 0 at a rising edge, the block SHALL:
  - enter IDLE;
  - clear ifu_rvalid, lsu_rvalid, mem_ren, mem_wen, the response register, the wait counter and bus_err;
  - set last_owner = LSU.
REQ-038 A transaction in flight when reset is taken SHALL be dropped with no response; a late mem_rvalid after reset SHALL be ignored.

Verification
REQ-039 IFU read: ifu_arvalid = 1, araddr = 0x80000000; SRAM returns 0x00000413 one cycle after the strobe -> mem_ren pulses once with mem_addr = 0x80000000, then ifu_rvalid = 1 with ifu_rdata = 0x00000413 until ifu_rready.
REQ-040 Tie: both requesters valid from reset for two transactions -> first grant IFU, second grant LSU; lsu_ready = 0 while IFU is in flight.
REQ-041 LSU write: addr 0x80001000, wdata 0x12345678, wmask 0x0F -> mem_wen pulses once with those values; lsu_rvalid = 1 with lsu_rdata = 0.
REQ-042 Timeout: mem_rvalid held 0 -> after TIMEOUT MEM cycles, owner rvalid = 1, rdata = 0xDEADBEEF, bus_err = 1 until reset.
REQ-043 Reset mid-MEM, then mem_rvalid pulses -> no rvalid on either requester; state is IDLE; the next IFU request is serviced normally.
REQ-044 Backpressure: ifu_rready held 0 for 5 cycles in RESP -> ifu_rdata stable, no SRAM strobes, lsu_ready stays 0.
